// File: rtl/rbm_sequencer_pkg.sv
// Shared defaults, index widths and FSM state type for the RBM sequencer.
package rbm_pkg;

    localparam int RBM_N_PIXEL  = 784;
    localparam int RBM_N_HIDDEN = 441;
    localparam int RBM_N_CLASS  = 10;
    localparam int RBM_W        = 12;
    localparam int RBM_N_ITER   = 30;
    localparam int RBM_CW       = 5;

    // Fixed widths of the memory-side index buses.
    localparam int PID_W = 10;
    localparam int HID_W = 9;
    localparam int SID_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HID  = 2'd1,
        ST_CLS  = 2'd2,
        ST_DONE = 2'd3
    } rbm_state_e;

endpackage

// File: rtl/rbm_sequencer_if.sv
// Control, memory-side and core-side signals of the RBM sequencer.
// master: the sequencer; slave: the memories, the core and the controller.
interface rbm_sequencer_if #(
    parameter int W = rbm_pkg::RBM_W
);
    import rbm_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic [PID_W-1:0] pixel_id;
    logic [HID_W-1:0] hidden_id;
    logic [SID_W-1:0] spike_id;
    logic             pixel_in;
    logic [W-1:0]     h_weight_in;
    logic [W-1:0]     h_bias_in;
    logic [W-1:0]     c_weight_in;
    logic [W-1:0]     c_bias_in;
    logic [W-1:0]     Hvalue;
    logic [W-1:0]     Cvalue;
    logic             pixel;
    logic             hidden_pixel;
    logic             enable_hidden;
    logic             enable_classi;
    logic             hidden;
    logic             spike;

    modport master (
        input  start, pixel_in, h_weight_in, h_bias_in, c_weight_in, c_bias_in, hidden, spike,
        output busy, done, pixel_id, hidden_id, spike_id,
               Hvalue, Cvalue, pixel, hidden_pixel, enable_hidden, enable_classi
    );

    modport slave (
        output start, pixel_in, h_weight_in, h_bias_in, c_weight_in, c_bias_in, hidden, spike,
        input  busy, done, pixel_id, hidden_id, spike_id,
               Hvalue, Cvalue, pixel, hidden_pixel, enable_hidden, enable_classi
    );

endinterface

// File: rtl/rbm_spike_counter_bank.sv
// Per-class saturating spike counters; define RBM_SEQ_ARGMAX_EN to add a
// registered label output holding the lowest index of the largest count.
module rbm_spike_counter_bank
    import rbm_pkg::*;
#(
    parameter int N_CLASS = RBM_N_CLASS,
    parameter int CW      = RBM_CW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  inc_i,
    input  logic [SID_W-1:0]      class_i,
    input  logic                  spike_i,
    output logic [N_CLASS*CW-1:0] count_o
`ifdef RBM_SEQ_ARGMAX_EN
    ,
    output logic [3:0]            label_o
`endif
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] cnt_q [N_CLASS];
    logic [CW-1:0] cnt_d [N_CLASS];

    // Clear on run start; otherwise add a captured spike to the selected class, holding at full scale.
    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            // NOTE: each counter takes its held value first, so no branch leaves it unassigned and no latch appears.
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
            end else if (inc_i && spike_i && (class_i == SID_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values regardless of block ordering.
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_CLASS; g++) begin : g_pack
        assign count_o[g*CW +: CW] = cnt_q[g];
    end

`ifdef RBM_SEQ_ARGMAX_EN
    logic [3:0]    label_d;
    logic [3:0]    label_q;
    logic [CW-1:0] best;

    // Argmax over next-state counts so the registered label tracks the counts in the same cycle.
    always_comb begin
        label_d = '0;
        best    = cnt_d[0];
        for (int i = 1; i < N_CLASS; i++) begin
            if (cnt_d[i] > best) begin
                best    = cnt_d[i];
                label_d = 4'(i);
            end
        end
    end

    // Label register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_q <= '0;
        end else begin
            label_q <= label_d;
        end
    end

    assign label_o = label_q;
`endif

endmodule

// File: rtl/rbm_sequencer.sv
// RBM sampling sequencer: walks the hidden phase (pixels x hidden units) and the
// classifier phase (hidden units x classes) N_ITER times, counting class spikes.
// Define RBM_SEQ_ARGMAX_EN to add the label output.
module rbm_sequencer
    import rbm_pkg::*;
#(
    parameter int N_PIXEL  = RBM_N_PIXEL,
    parameter int N_HIDDEN = RBM_N_HIDDEN,
    parameter int N_CLASS  = RBM_N_CLASS,
    parameter int W        = RBM_W,
    parameter int N_ITER   = RBM_N_ITER,
    parameter int CW       = RBM_CW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rbm_sequencer_if.master       bus,
    output logic [N_CLASS*CW-1:0] count_o
`ifdef RBM_SEQ_ARGMAX_EN
    ,
    output logic [3:0]            label_o
`endif
);

    localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    localparam logic [PID_W-1:0] PIX_BIAS  = PID_W'(N_PIXEL);
    localparam logic [PID_W-1:0] PIX_CAP   = PID_W'(N_PIXEL + 1);
    localparam logic [HID_W-1:0] HID_LAST  = HID_W'(N_HIDDEN - 1);
    localparam logic [HID_W-1:0] HID_BIAS  = HID_W'(N_HIDDEN);
    localparam logic [HID_W-1:0] HID_CAP   = HID_W'(N_HIDDEN + 1);
    localparam logic [SID_W-1:0] CLS_LAST  = SID_W'(N_CLASS - 1);
    localparam logic [IW-1:0]    ITER_LAST = IW'(N_ITER - 1);

    rbm_state_e          state_q, state_d;
    logic [PID_W-1:0]    pixel_id_q, pixel_id_d;
    logic [HID_W-1:0]    hidden_id_q, hidden_id_d;
    logic [SID_W-1:0]    spike_id_q, spike_id_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [N_HIDDEN-1:0] hbuf_q, hbuf_d;
    logic                start_acc;
    logic                cls_capture;
    logic                hbuf_rd;

    assign start_acc   = (state_q == ST_IDLE) && bus.start;
    assign cls_capture = (state_q == ST_CLS) && (hidden_id_q == HID_CAP);

    // Phase/step sequencing and hidden-unit capture.
    always_comb begin
        state_d     = state_q;
        pixel_id_d  = pixel_id_q;
        hidden_id_d = hidden_id_q;
        spike_id_d  = spike_id_q;
        iter_d      = iter_q;
        hbuf_d      = hbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d     = ST_HID;
                    pixel_id_d  = '0;
                    hidden_id_d = '0;
                    spike_id_d  = '0;
                    iter_d      = '0;
                    hbuf_d      = '0;
                end
            end
            ST_HID: begin
                if (pixel_id_q == PIX_CAP) begin
                    for (int i = 0; i < N_HIDDEN; i++) begin
                        if (hidden_id_q == HID_W'(i)) begin
                            hbuf_d[i] = bus.hidden;
                        end
                    end
                    pixel_id_d = '0;
                    if (hidden_id_q == HID_LAST) begin
                        state_d     = ST_CLS;
                        hidden_id_d = '0;
                        spike_id_d  = '0;
                    end else begin
                        hidden_id_d = hidden_id_q + HID_W'(1);
                    end
                end else begin
                    pixel_id_d = pixel_id_q + PID_W'(1);
                end
            end
            ST_CLS: begin
                if (hidden_id_q == HID_CAP) begin
                    hidden_id_d = '0;
                    if (spike_id_q == CLS_LAST) begin
                        spike_id_d = '0;
                        if (iter_q == ITER_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_HID;
                            iter_d  = iter_q + IW'(1);
                        end
                    end else begin
                        spike_id_d = spike_id_q + SID_W'(1);
                    end
                end else begin
                    hidden_id_d = hidden_id_q + HID_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, index and hidden-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pixel_id_q  <= '0;
            hidden_id_q <= '0;
            spike_id_q  <= '0;
            iter_q      <= '0;
            // NOTE: the hidden buffer must read as zero after reset, so it lives in the reset branch rather than in reset-less storage.
            hbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            pixel_id_q  <= pixel_id_d;
            hidden_id_q <= hidden_id_d;
            spike_id_q  <= spike_id_d;
            iter_q      <= iter_d;
            hbuf_q      <= hbuf_d;
        end
    end

    // Read back the buffered hidden bit for the current classifier step.
    always_comb begin
        hbuf_rd = 1'b0;
        for (int i = 0; i < N_HIDDEN; i++) begin
            if (hidden_id_q == HID_W'(i)) begin
                hbuf_rd = hbuf_q[i];
            end
        end
    end

    // Core operands: weight steps pass memory data, the bias step forces the gate high, capture steps drive zero.
    always_comb begin
        bus.Hvalue       = '0;
        bus.Cvalue       = '0;
        bus.pixel        = 1'b0;
        bus.hidden_pixel = 1'b0;
        if (state_q == ST_HID) begin
            if (pixel_id_q < PIX_BIAS) begin
                bus.Hvalue = bus.h_weight_in;
                bus.pixel  = bus.pixel_in;
            end else if (pixel_id_q == PIX_BIAS) begin
                bus.Hvalue = bus.h_bias_in;
                bus.pixel  = 1'b1;
            end
        end else if (state_q == ST_CLS) begin
            if (hidden_id_q < HID_BIAS) begin
                bus.Cvalue       = bus.c_weight_in;
                bus.hidden_pixel = hbuf_rd;
            end else if (hidden_id_q == HID_BIAS) begin
                bus.Cvalue       = bus.c_bias_in;
                bus.hidden_pixel = 1'b1;
            end
        end
    end

    assign bus.busy          = (state_q == ST_HID) || (state_q == ST_CLS);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.enable_hidden = (state_q == ST_HID);
    assign bus.enable_classi = (state_q == ST_CLS);
    assign bus.pixel_id      = pixel_id_q;
    assign bus.hidden_id     = hidden_id_q;
    assign bus.spike_id      = spike_id_q;

    rbm_spike_counter_bank #(
        .N_CLASS (N_CLASS),
        .CW      (CW)
    ) u_counters (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (start_acc),
        .inc_i   (cls_capture),
        .class_i (spike_id_q),
        .spike_i (bus.spike),
        .count_o (count_o)
`ifdef RBM_SEQ_ARGMAX_EN
        ,
        .label_o (label_o)
`endif
    );

endmodule

// File: tb/tb_rbm_sequencer.sv
// Scoreboard bench for rbm_sequencer with a small geometry; the memories and
// the core are modelled by combinational functions of the DUT index outputs.
module tb_rbm_sequencer;

    localparam int NP   = 4;
    localparam int NH   = 3;
    localparam int NC   = 8;
    localparam int WW   = 12;
    localparam int NI   = 10;
    localparam int CWW  = 3;
    localparam int CMAX = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rbm_sequencer_if #(.W(WW)) bus ();
    logic [NC*CWW-1:0] count;
`ifdef RBM_SEQ_ARGMAX_EN
    logic [3:0] label;
`endif

    rbm_sequencer #(
        .N_PIXEL  (NP),
        .N_HIDDEN (NH),
        .N_CLASS  (NC),
        .W        (WW),
        .N_ITER   (NI),
        .CW       (CWW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .count_o (count)
`ifdef RBM_SEQ_ARGMAX_EN
        ,
        .label_o (label)
`endif
    );

    int cur_mode = 1;
    int cur_iter = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt [NC];

    typedef struct {
        logic [63:0] v;
        int          idx;
    } sb_t;
    sb_t sb_q [$];

    // Memory contents and core behaviour.
    function automatic logic img_f(int p);
        return ((p * 3 + 1) % 5) > 1;
    endfunction
    function automatic logic [WW-1:0] hw_f(int p, int h);
        return WW'(p * 37 + h * 101 + 5);
    endfunction
    function automatic logic [WW-1:0] hb_f(int h);
        return WW'(h * 211 + 900);
    endfunction
    function automatic logic [WW-1:0] cw_f(int j, int k);
        return WW'(j * 53 + k * 17 + 2000);
    endfunction
    function automatic logic [WW-1:0] cb_f(int k);
        return WW'(k * 29 + 3000);
    endfunction
    function automatic logic hid_f(int h);
        return h != 1;
    endfunction
    function automatic logic spike_f(int m, int it, int k);
        case (m)
            0:       return it < k;
            1:       return 1'b1;
            default: return (k == 3) || (k == 7);
        endcase
    endfunction

    assign bus.pixel_in    = img_f(int'(bus.pixel_id));
    assign bus.h_weight_in = hw_f(int'(bus.pixel_id), int'(bus.hidden_id));
    assign bus.h_bias_in   = hb_f(int'(bus.hidden_id));
    assign bus.c_weight_in = cw_f(int'(bus.hidden_id), int'(bus.spike_id));
    assign bus.c_bias_in   = cb_f(int'(bus.spike_id));
    assign bus.hidden      = hid_f(int'(bus.hidden_id));
    assign bus.spike       = spike_f(cur_mode, cur_iter, int'(bus.spike_id));

    logic [63:0] dut_vec;
    assign dut_vec = {11'b0, bus.enable_hidden, bus.enable_classi, bus.busy, bus.done,
                      bus.pixel_id, bus.hidden_id, bus.spike_id,
                      bus.Hvalue, bus.Cvalue, bus.pixel, bus.hidden_pixel};

    function automatic logic [63:0] mk_vec(logic eh, logic ec, logic bz, logic dn,
                                           int p, int h, int s,
                                           logic [WW-1:0] hv, logic [WW-1:0] cv,
                                           logic px, logic hp);
        return {11'b0, eh, ec, bz, dn, 10'(p), 9'(h), 4'(s), hv, cv, px, hp};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_label();
        int best = exp_cnt[0];
        int lbl  = 0;
        for (int k = 1; k < NC; k++) begin
            if (exp_cnt[k] > best) begin
                best = exp_cnt[k];
                lbl  = k;
            end
        end
        return lbl;
    endfunction

    task automatic check_counts(input string tag);
        for (int k = 0; k < NC; k++) begin
            check($sformatf("%s_count%0d", tag, k), 64'(count[k*CWW +: CWW]), 64'(exp_cnt[k]));
        end
`ifdef RBM_SEQ_ARGMAX_EN
        check({tag, "_label"}, 64'(label), 64'(exp_label()));
`endif
    endtask

    // Monitor: compare the DUT against the oldest expected cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check($sformatf("cyc%0d", e.idx), dut_vec, e.v);
        end
    end

    task automatic push(input logic [63:0] v, input int idx);
        sb_t e;
        e.v   = v;
        e.idx = idx;
        sb_q.push_back(e);
    endtask

    // One run: start, then predict every cycle. abort_at >= 0 stops early (for the reset test).
    task automatic run_pass(input int mode, input bit extra_start, input int abort_at);
        int cyc = 0;
        for (int k = 0; k < NC; k++) exp_cnt[k] = 0;
        cur_mode = mode;
        cur_iter = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int it = 0; it < NI; it++) begin
            cur_iter = it;
            for (int h = 0; h < NH; h++) begin
                for (int s = 0; s < NP + 2; s++) begin
                    if (cyc == abort_at) return;
                    bus.start = extra_start && (cyc % 37 == 3);
                    if (s < NP)       push(mk_vec(1, 0, 1, 0, s, h, 0, hw_f(s, h), '0, img_f(s), 0), cyc);
                    else if (s == NP) push(mk_vec(1, 0, 1, 0, s, h, 0, hb_f(h), '0, 1, 0), cyc);
                    else              push(mk_vec(1, 0, 1, 0, s, h, 0, '0, '0, 0, 0), cyc);
                    cyc++;
                    @(posedge clk); #1;
                end
            end
            for (int k = 0; k < NC; k++) begin
                for (int j = 0; j < NH + 2; j++) begin
                    bus.start = extra_start && (cyc % 37 == 3);
                    if (j < NH)       push(mk_vec(0, 1, 1, 0, 0, j, k, '0, cw_f(j, k), 0, hid_f(j)), cyc);
                    else if (j == NH) push(mk_vec(0, 1, 1, 0, 0, j, k, '0, cb_f(k), 0, 1), cyc);
                    else begin
                        push(mk_vec(0, 1, 1, 0, 0, j, k, '0, '0, 0, 0), cyc);
                        if (spike_f(mode, it, k) && exp_cnt[k] < CMAX) exp_cnt[k]++;
                    end
                    cyc++;
                    @(posedge clk); #1;
                end
            end
        end
        bus.start = 1'b0;
        push(mk_vec(0, 0, 0, 1, 0, 0, 0, '0, '0, 0, 0), cyc);
        @(negedge clk);
        check_counts($sformatf("m%0d_done", mode));
        @(posedge clk); #1;
        push(mk_vec(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 0), cyc + 1);
        @(negedge clk);
        check_counts($sformatf("m%0d_idle", mode));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_vec", dut_vec, 64'd0);
        check("reset_count", 64'(count), 64'd0);
        #20 rst_n = 1'b1;

        // Graded spike counts, with start pulses while busy.
        run_pass(0, 1'b1, -1);

        // Reset in the middle of the hidden phase.
        run_pass(1, 1'b0, 15);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_vec", dut_vec, 64'd0);
        check("midrun_rst_count", 64'(count), 64'd0);
`ifdef RBM_SEQ_ARGMAX_EN
        check("midrun_rst_label", 64'(label), 64'd0);
`endif
        #2 rst_n = 1'b1;
        sb_q.delete();

        // Every class spikes every iteration: counts saturate.
        run_pass(1, 1'b0, -1);

        // Only classes 3 and 7 spike: tie at full scale.
        run_pass(2, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
